// File: rtl/hilo_muldiv_engine.sv
// hilo_muldiv_engine
//   Multi-cycle multiply/divide engine that owns the Hi/Lo register pair.
//   Handles MULT, MULTU, DIV and DIVU with one iteration per clock, plus
//   direct MTHI/MTLO writes.
//
//   Sequence: IDLE -> PREP -> RUN (WIDTH cycles) -> FIX -> DONE -> IDLE.
//   A start seen in DONE launches the next operation back to back.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   start     launch op/src_a/src_b (taken only while busy=0)
//   op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a     multiplicand / dividend
//   src_b     multiplier / divisor
//   hi_wr     MTHI: hi <= wdata (taken only while busy=0)
//   lo_wr     MTLO: lo <= wdata (taken only while busy=0)
//   wdata     data for hi_wr / lo_wr
//   busy      high in PREP, RUN, FIX
//   done      one-cycle pulse in DONE
//   div_zero  pulses with done when a divide had a zero divisor
//   hi, lo    result registers (remainder/quotient or product high/low)
module hilo_muldiv_engine #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]         op_reg;
    logic [WIDTH-1:0]   a_reg;      // multiplicand, or dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   rem_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CW-1:0]      cnt_reg;
    logic               sign_a_reg;
    logic               sign_b_reg;
    logic               div_zero_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    logic               zero_div;
    logic               last_iter;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    assign busy     = (state_reg == S_PREP) || (state_reg == S_RUN) || (state_reg == S_FIX);
    assign done     = (state_reg == S_DONE);
    assign div_zero = (state_reg == S_DONE) && div_zero_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;

    assign zero_div  = op_reg[1] && (b_reg == '0);
    assign last_iter = (cnt_reg == CW'(WIDTH - 1));

    always_comb begin
        rem_shift  = {rem_reg, a_reg[WIDTH-1]};
        // Both operands are below 2^(WIDTH+1) and rem_shift < 2*b, so the
        // top bit of the difference is a reliable borrow flag.
        rem_diff   = rem_shift - {1'b0, b_reg};
        prod_fixed = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
        quo_fixed  = (sign_a_reg ^ sign_b_reg) ? -a_reg : a_reg;
        rem_fixed  = sign_a_reg ? -rem_reg : rem_reg;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_PREP;
            S_PREP:  state_next = zero_div ? S_DONE : S_RUN;
            S_RUN:   if (last_iter) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = start ? S_PREP : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            rem_reg      <= '0;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            sign_a_reg   <= 1'b0;
            sign_b_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
        end else begin
            // MTHI/MTLO apply whenever the engine is not busy, even when a
            // start is taken in the same cycle; the result overwrites later.
            if (!busy && hi_wr) hi_reg <= wdata;
            if (!busy && lo_wr) lo_reg <= wdata;

            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_reg       <= op;
                        a_reg        <= src_a;
                        b_reg        <= src_b;
                        div_zero_reg <= 1'b0;
                    end
                end
                S_PREP: begin
                    acc_reg <= '0;
                    rem_reg <= '0;
                    cnt_reg <= '0;
                    if (!op_reg[0]) begin
                        // Magnitude of -2^(WIDTH-1) is still representable unsigned.
                        sign_a_reg <= a_reg[WIDTH-1];
                        sign_b_reg <= b_reg[WIDTH-1];
                        a_reg      <= a_reg[WIDTH-1] ? -a_reg : a_reg;
                        b_reg      <= b_reg[WIDTH-1] ? -b_reg : b_reg;
                    end else begin
                        sign_a_reg <= 1'b0;
                        sign_b_reg <= 1'b0;
                    end
                    if (zero_div) div_zero_reg <= 1'b1;
                end
                S_RUN: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (!op_reg[1]) begin
                        // MSB-first shift-add multiply.
                        acc_reg <= {acc_reg[2*WIDTH-2:0], 1'b0}
                                 + (a_reg[WIDTH-1] ? {{WIDTH{1'b0}}, b_reg} : '0);
                        a_reg   <= {a_reg[WIDTH-2:0], 1'b0};
                    end else begin
                        // Restoring division: dividend bits leave the top of
                        // a_reg while quotient bits enter at the bottom.
                        if (!rem_diff[WIDTH]) begin
                            rem_reg <= rem_diff[WIDTH-1:0];
                            a_reg   <= {a_reg[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_reg <= rem_shift[WIDTH-1:0];
                            a_reg   <= {a_reg[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                S_FIX: begin
                    if (op_reg[1]) begin
                        lo_reg <= quo_fixed;
                        hi_reg <= rem_fixed;
                    end else begin
                        hi_reg <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_fixed[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_engine.sv
// Testbench for hilo_muldiv_engine (WIDTH=32): directed corner cases plus
// randomized ops, compared against an arithmetic reference model.
module tb_hilo_muldiv_engine;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         hi_wr;
    logic         lo_wr;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference copies of Hi/Lo.
    logic [W-1:0] mdl_hi = '0;
    logic [W-1:0] mdl_lo = '0;

    always #5 clk = ~clk;

    hilo_muldiv_engine #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .hi_wr    (hi_wr),
        .lo_wr    (lo_wr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result for one op using plain integer arithmetic.
    task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic dz);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        dz = 1'b0;
        case (o)
            2'b00: begin
                sq = sa * sb;
                {mdl_hi, mdl_lo} = sq;
            end
            2'b01: begin
                up = ua * ub;
                {mdl_hi, mdl_lo} = up;
            end
            2'b10: begin
                if (b == 0) dz = 1'b1;
                else begin
                    sq = sa / sb;       // truncates toward zero
                    sr = sa % sb;       // sign follows dividend
                    mdl_lo = sq[W-1:0];
                    mdl_hi = sr[W-1:0];
                end
            end
            default: begin
                if (b == 0) dz = 1'b1;
                else begin
                    mdl_lo = W'(ua / ub);
                    mdl_hi = W'(ua % ub);
                end
            end
        endcase
    endtask

    // Launch one op from a non-busy state (called #1 after an edge) and
    // follow it to DONE. With disturb set, a start and MTHI/MTLO are driven
    // for one cycle mid-RUN and must be ignored.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit disturb);
        logic dz;
        int   n;
        model(o, a, b, dz);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        n = 0;
        while (!done && n < 200) begin
            if (disturb && n == 5) begin
                start = 1'b1; op = ~o; src_a = $urandom; src_b = $urandom;
                hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'h5A5A_5A5A;
            end
            @(posedge clk); #1;
            n++;
            if (disturb && n == 6) begin
                start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
            end
            if (!done && n > 1) check("busy_mid", busy, 1);
        end
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d lat=%0d", o, a, b, hi, lo, div_zero, n);
        check("latency", n, dz ? 1 : W + 2);
        check("done", done, 1);
        check("busy_in_done", busy, 0);
        check("div_zero", div_zero, dz);
        check("hi", hi, mdl_hi);
        check("lo", lo, mdl_lo);
    endtask

    task automatic mt_write(input logic wh, input logic wl, input logic [W-1:0] d);
        hi_wr = wh; lo_wr = wl; wdata = d;
        @(posedge clk); #1;
        hi_wr = 1'b0; lo_wr = 1'b0;
        if (wh) mdl_hi = d;
        if (wl) mdl_lo = d;
        $display("mt hi_wr=%0d lo_wr=%0d d=%h -> hi=%h lo=%h", wh, wl, d, hi, lo);
        check("mt_hi", hi, mdl_hi);
        check("mt_lo", lo, mdl_lo);
    endtask

    initial begin
        int n_done;
        logic [1:0] ro;
        logic [W-1:0] ra, rb;

        reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        hi_wr = 1'b0; lo_wr = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_zero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        @(posedge clk); #1;
        check("idle_done", done, 0);

        // MTHI/MTLO, then divide by zero leaves them intact.
        mt_write(1'b1, 1'b0, 32'h0000_00AA);
        mt_write(1'b0, 1'b1, 32'h1234_5678);
        mt_write(1'b1, 1'b1, 32'hCAFE_0001);
        mt_write(1'b1, 1'b0, 32'h0000_00AA);
        run_op(2'b10, 32'd77, 32'd0, 1'b0);
        run_op(2'b11, 32'hFFFF_0000, 32'd0, 1'b0);

        // Write taken together with start, then overwritten by the result.
        hi_wr = 1'b1; wdata = 32'hDEAD_BEEF;
        start = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd9;
        @(posedge clk); #1;
        hi_wr = 1'b0; start = 1'b0;
        $display("write-with-start -> hi=%h", hi);
        check("wr_with_start_hi", hi, 32'hDEAD_BEEF);
        repeat (W + 2) @(posedge clk);
        #1;
        check("wr_with_start_done", done, 1);
        check("wr_with_start_res_hi", hi, 0);
        check("wr_with_start_res_lo", lo, 81);
        mdl_hi = 0; mdl_lo = 81;

        // Inputs driven during RUN are ignored.
        run_op(2'b00, 32'hFFFF_FF00, 32'h0000_0123, 1'b1);
        run_op(2'b11, 32'h0BAD_F00D, 32'h0000_1001, 1'b1);

        // Reset mid-RUN aborts without a done pulse.
        start = 1'b1; op = 2'b01; src_a = 32'h1111_1111; src_b = 32'h2222_2222;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        $display("reset mid-run -> busy=%0d hi=%h lo=%h", busy, hi, lo);
        check("abort_busy", busy, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        mdl_hi = 0; mdl_lo = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < W + 6; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 1'b0);

        // Randomized ops, back to back (each launch happens from DONE).
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 0;
                1: rb = 32'(int'($urandom_range(0, 4)) - 2);
                2: ra = 32'h8000_0000;
                3: rb = rb >> $urandom_range(8, 31);
                default: ;
            endcase
            run_op(ro, ra, rb, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
